// File: rtl/nano_line_rx.sv
// nano_line_rx: 8N1 LSB-first serial receiver for the nanoTX line output.
// Recovers bytes and pairs them into 16-bit words, low byte first.
module nano_line_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        line,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        byte_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ls;
  logic                   ls_prev_q;
  logic                   fall;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      lo_q, lo_d;
  logic            phase_q, phase_d;  // 0: expect low byte, 1: expect high byte
  logic [15:0]     word_q, word_d;
  logic            wv_q, wv_d;
  logic            bv_q, bv_d;
  logic            fe_q, fe_d;
  logic            busy_q, busy_d;

  assign ls   = sync_q[SYNC_STAGES-1];
  assign fall = ls_prev_q & ~ls;

  // Input synchronizer and edge-detect history; reset to idle level so no false start.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      ls_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], line};
      ls_prev_q <= ls;
    end
  end

  // Next-state logic: frame FSM, baud/bit counters, byte pairing and output pulses.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    lo_d      = lo_q;
    phase_d   = phase_q;
    word_d    = word_q;
    wv_d      = 1'b0;
    bv_d      = 1'b0;
    fe_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Edge-triggered so a held-low line cannot restart the FSM.
        if (fall) begin
          state_d = StStart;
          baud_d  = HalfLoad;
        end
      end
      StStart: begin
        if (baud_q == '0) begin
          if (!ls) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
            baud_d    = BitLoad;
          end else begin
            state_d = StIdle;  // glitch, not a real start bit
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        if (baud_q == '0) begin
          shreg_d[bit_idx_q] = ls;
          baud_d             = BitLoad;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (baud_q == '0) begin
          // Leaving at mid-stop lets a start bit directly after the stop be caught.
          state_d = StIdle;
          if (ls) begin
            bv_d = 1'b1;
            if (!phase_q) begin
              lo_d    = shreg_q;
              phase_d = 1'b1;
            end else begin
              word_d  = {shreg_q, lo_q};
              wv_d    = 1'b1;
              phase_d = 1'b0;
            end
          end else begin
            fe_d    = 1'b1;
            phase_d = 1'b0;  // drop any pending low byte
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      lo_q      <= 8'h00;
      phase_q   <= 1'b0;
      word_q    <= 16'h0000;
      wv_q      <= 1'b0;
      bv_q      <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      lo_q      <= lo_d;
      phase_q   <= phase_d;
      word_q    <= word_d;
      wv_q      <= wv_d;
      bv_q      <= bv_d;
      fe_q      <= fe_d;
      busy_q    <= busy_d;
    end
  end

  assign word       = word_q;
  assign word_valid = wv_q;
  assign byte_valid = bv_q;
  assign frame_err  = fe_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_nano_line_rx.sv
// Bench for nano_line_rx: directed frames, word table, and multi-cycle corner cases.
module tb_nano_line_rx;

  localparam int C   = 16;
  localparam int S   = 2;
  localparam int LAT = 2 + S + C / 2 + 9 * C;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        line = 1'b1;
  logic [15:0] word;
  logic        word_valid, byte_valid, frame_err, busy;

  nano_line_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(S)) dut (
    .ck         (ck),
    .rst        (rst),
    .line       (line),
    .word       (word),
    .word_valid (word_valid),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int bv_cnt = 0, wv_cnt = 0, fe_cnt = 0;
  logic [15:0] wq[$];

  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Event monitor: counts pulses, captures words, checks byte latency.
  always @(negedge ck) begin
    if (!rst) begin
      if (byte_valid) begin
        bv_cnt++;
        checks++;
        if ((cyc - last_start) < LAT - 1 || (cyc - last_start) > LAT + 1) begin
          errors++;
          $display("FAIL latency: got %0d cycles expected %0d..%0d",
                   cyc - last_start, LAT - 1, LAT + 1);
        end
      end
      if (word_valid) begin
        wv_cnt++;
        wq.push_back(word);
      end
      if (frame_err) fe_cnt++;
    end
  end

  // Drives one frame; called at a falling clock edge, returns at one.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    line = 1'b0;
    last_start = cyc;
    repeat (C) @(negedge ck);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (C) @(negedge ck);
    end
    line = stop;
    repeat (C) @(negedge ck);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge ck);
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[15];
  int   bv0, wv0, fe0, wb;
  logic saw_busy;

  initial begin
    vecs[0]  = '{8'hFC, 8'hAB, 16'hABFC};
    vecs[1]  = '{8'h00, 8'h00, 16'h0000};
    vecs[2]  = '{8'h01, 8'h00, 16'h0001};
    vecs[3]  = '{8'h01, 8'h00, 16'h0001};
    vecs[4]  = '{8'h02, 8'h00, 16'h0002};
    vecs[5]  = '{8'h03, 8'h00, 16'h0003};
    vecs[6]  = '{8'h05, 8'h00, 16'h0005};
    vecs[7]  = '{8'h08, 8'h00, 16'h0008};
    vecs[8]  = '{8'h0D, 8'h00, 16'h000D};
    vecs[9]  = '{8'h15, 8'h00, 16'h0015};
    vecs[10] = '{8'h22, 8'h00, 16'h0022};
    vecs[11] = '{8'h37, 8'h00, 16'h0037};
    vecs[12] = '{8'h59, 8'h00, 16'h0059};
    vecs[13] = '{8'h90, 8'h00, 16'h0090};
    vecs[14] = '{8'hE9, 8'h00, 16'h00E9};

    // Reset state
    repeat (3) @(negedge ck);
    check("rst_word", {16'h0, word}, 32'h0);
    check("rst_word_valid", {31'h0, word_valid}, 32'h0);
    check("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    idle(4);

    // Two frames 0xFC, 0xAB
    bv0 = bv_cnt; wv0 = wv_cnt; fe0 = fe_cnt; wb = wq.size();
    send_frame(vecs[0].lo, 1'b1);
    send_frame(vecs[0].hi, 1'b1);
    idle(2 * C);
    check("pair_bytes", bv_cnt - bv0, 2);
    check("pair_words", wv_cnt - wv0, 1);
    check("pair_ferr", fe_cnt - fe0, 0);
    check("pair_word", {16'h0, (wq.size() > wb) ? wq[wb] : 16'hxxxx}, {16'h0, vecs[0].exp});

    // Fibonacci words back-to-back
    bv0 = bv_cnt; wv0 = wv_cnt; fe0 = fe_cnt; wb = wq.size();
    for (int i = 1; i < 15; i++) begin
      send_frame(vecs[i].lo, 1'b1);
      send_frame(vecs[i].hi, 1'b1);
    end
    idle(2 * C);
    check("fib_bytes", bv_cnt - bv0, 28);
    check("fib_words", wv_cnt - wv0, 14);
    check("fib_ferr", fe_cnt - fe0, 0);
    for (int i = 1; i < 15; i++) begin
      check($sformatf("fib_word%0d", i),
            {16'h0, (wq.size() > wb + i - 1) ? wq[wb + i - 1] : 16'hxxxx}, {16'h0, vecs[i].exp});
    end

    // Pending low byte, then bad stop bit, then 0x00 0x01
    bv0 = bv_cnt; wv0 = wv_cnt; fe0 = fe_cnt; wb = wq.size();
    send_frame(8'h99, 1'b1);
    send_frame(8'h0A, 1'b0);
    idle(2 * C);
    check("ferr_count", fe_cnt - fe0, 1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h01, 1'b1);
    idle(2 * C);
    check("ferr_bytes", bv_cnt - bv0, 3);
    check("ferr_words", wv_cnt - wv0, 1);
    check("ferr_word", {16'h0, (wq.size() > wb) ? wq[wb] : 16'hxxxx}, 32'h0100);

    // Short low glitch on idle line
    bv0 = bv_cnt; fe0 = fe_cnt;
    saw_busy = 1'b0;
    line = 1'b0;
    for (int i = 1; i <= C / 2 + S + 2; i++) begin
      @(negedge ck);
      if (i == 3) line = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    check("glitch_busy_rose", {31'h0, saw_busy}, 32'h1);
    check("glitch_busy_fell", {31'h0, busy}, 32'h0);
    idle(3 * C);
    check("glitch_bytes", bv_cnt - bv0, 0);
    check("glitch_ferr", fe_cnt - fe0, 0);

    // Asynchronous reset mid DATA with a low byte pending
    send_frame(8'h77, 1'b1);
    line = 1'b0;
    last_start = cyc;
    repeat (C) @(negedge ck);
    line = 1'b0;
    repeat (3 * C) @(negedge ck);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    #3 rst = 1'b1;
    line = 1'b1;
    #1;
    check("async_rst_word", {16'h0, word}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_bv", {31'h0, byte_valid}, 32'h0);
    repeat (4) @(negedge ck);
    rst = 1'b0;
    idle(4);
    bv0 = bv_cnt; wv0 = wv_cnt; wb = wq.size();
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);
    idle(2 * C);
    check("post_rst_words", wv_cnt - wv0, 1);
    check("post_rst_word", {16'h0, (wq.size() > wb) ? wq[wb] : 16'hxxxx}, 32'h1234);

    // Break: line low for 20 bit periods
    bv0 = bv_cnt; wv0 = wv_cnt; fe0 = fe_cnt; wb = wq.size();
    line = 1'b0;
    last_start = cyc;
    repeat (20 * C) @(negedge ck);
    idle(2 * C);
    check("break_ferr", fe_cnt - fe0, 1);
    check("break_bytes", bv_cnt - bv0, 0);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle(2 * C);
    check("break_ferr_total", fe_cnt - fe0, 1);
    check("break_words", wv_cnt - wv0, 1);
    check("break_word", {16'h0, (wq.size() > wb) ? wq[wb] : 16'hxxxx}, 32'hAA55);
    check("hold_word", {16'h0, word}, 32'hAA55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nano_line_rx.md
Name: nano_line_rx

Overview:
- Serial receiver for the `line` output of the nanoTX core; the opposite end of the CPU's transmit path.
- Samples an idle-high, 8N1, LSB-first asynchronous line and recovers bytes.
- Pairs bytes into 16-bit words, low byte first, matching the CPU data width.
- Presents each word to the bench or the SoC with a one-cycle valid strobe, plus error and busy status.

Parameters:
- CLKS_PER_BIT, 16, ck cycles per serial bit period; legal range 4..4095.
- SYNC_STAGES, 2, number of flops in the input synchronizer chain; legal range 2..3.

Ports:
- ck  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- line  input  1  serial data from nanoTX; idle level is 1.
- word  output  16  last assembled word; {high byte, low byte}.
- word_valid  output  1  one-cycle pulse when `word` is updated.
- byte_valid  output  1  one-cycle pulse per correctly framed byte.
- frame_err  output  1  one-cycle pulse when a stop bit samples 0.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset: all outputs are 0. The synchronizer flops reset to 1, so reset does not create a false start bit. FSM goes to IDLE, the bit counter and baud counter go to 0, and the byte-phase flag is cleared to "expect low byte". Reset mid-frame abandons the partial frame and any pending low byte.
- Synchronizer: `line` passes through SYNC_STAGES flops; `ls` is the synchronized value. Falling-edge detect compares `ls` with its previous value.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on `ls` moves to START and loads baud_cnt = CLKS_PER_BIT/2 - 1 (integer division).
  - START: when baud_cnt reaches 0, sample `ls`.
    - `ls` = 0: go to DATA, set bit_idx = 0, reload baud_cnt = CLKS_PER_BIT - 1.
    - `ls` = 1: glitch; return to IDLE without pulsing any output.
  - DATA: when baud_cnt reaches 0, shift `ls` into shreg[bit_idx] (LSB first) and reload baud_cnt. After bit_idx 7, go to STOP; otherwise increment bit_idx.
  - STOP: when baud_cnt reaches 0, sample `ls`.
    - `ls` = 1: pulse byte_valid. If the phase flag says low byte, store the low byte and toggle the flag. If it says high byte, drive word = {shreg, low}, pulse word_valid in the same cycle as byte_valid, and toggle the flag.
    - `ls` = 0: pulse frame_err, discard the byte, and clear the phase flag (the partial word is dropped).
    - In both cases return to IDLE in the next cycle.
- Sampling point: every bit is sampled at mid-bit, measured from the detected falling edge.
- Latency: byte_valid and word_valid assert 2 + SYNC_STAGES + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT cycles after the `line` falling edge, ±1 cycle. The bench checks that window.
- Back-to-back frames: a start bit that immediately follows a stop bit is detected, because IDLE is re-entered at mid-stop. No idle gap between frames is required.
- `word` holds its value until the next word_valid; it is never cleared except by reset.
- A line held at 0 (break): produces one frame_err, then no further activity until `ls` returns to 1 and falls again, because the FSM waits for an edge and not a level.
- busy is registered and equals (state != IDLE).

Test Plan:
- Reset, then 2 frames with CLKS_PER_BIT=16: 0xFC then 0xAB -> byte_valid twice, one word_valid with word = 16'hABFC, frame_err never pulses.
- 14 Fibonacci words (0,1,1,2,...,233) sent back-to-back with no idle gap -> 14 word_valid pulses, values in order, latency within the stated window.
- 0x0A sent with the stop bit forced to 0, then 0x00 and 0x01 -> one frame_err, the phase flag resets, and the next word is 16'h0100.
- A 3-cycle low glitch on an idle line -> no byte_valid, no frame_err; busy rises and then returns to 0 within CLKS_PER_BIT/2 + SYNC_STAGES + 2 cycles.
- rst asserted asynchronously mid DATA after 1 of 2 bytes, then released; send 0x34, 0x12 -> outputs cleared immediately, and the first word afterwards is 16'h1234.
- Line held low for 20 bit periods, then released, then 0x55, 0xAA sent -> exactly one frame_err, followed by word = 16'hAA55.
